// File: rtl/fir_output_conditioner.sv
// fir_output_conditioner: decimate, round, saturate and FIFO-buffer wide FIR output onto a valid/ready stream.
module fir_output_conditioner #(
  parameter int IN_WIDTH   = 39,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 0,
  parameter int DECIM      = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [IN_WIDTH-1:0]           in_data,
  input  logic                          clr_stats,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [OUT_WIDTH-1:0]          m_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   sat_count,
  output logic [15:0]                   ovf_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = DECIM > 1 ? $clog2(DECIM) : 1;
  // Rounding offset 2^(SHIFT-1), collapsing to zero when SHIFT is 0.
  localparam logic signed [IN_WIDTH:0] HALF = ((IN_WIDTH+1)'(1) << SHIFT) >> 1;
  localparam logic signed [IN_WIDTH:0] MAXV = (IN_WIDTH+1)'((64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1);
  logic [DW-1:0] dcnt;
  logic keep, hi, lo, stg_v, push, pop, full, drop;
  logic signed [IN_WIDTH:0] sum, r;
  logic [OUT_WIDTH-1:0] sat_d, stg_d;
  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  always_comb begin
    keep = in_valid && dcnt == '0;
    sum = $signed({in_data[IN_WIDTH-1], in_data}) + HALF;
    r = sum >>> SHIFT;
    hi = r > MAXV;
    lo = r < ~MAXV;
    sat_d = hi ? {1'b0, {(OUT_WIDTH-1){1'b1}}} : lo ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : r[OUT_WIDTH-1:0];
    m_valid = fifo_level != '0;
    full = fifo_level == (AW+1)'(FIFO_DEPTH);
    pop = m_valid && m_ready;
    push = stg_v && (!full || pop);
    drop = stg_v && full && !pop;
    m_data = m_valid ? mem[rp] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt <= '0;
      stg_v <= 1'b0;
      stg_d <= '0;
      wp <= '0;
      rp <= '0;
      fifo_level <= '0;
      sat_count <= '0;
      ovf_count <= '0;
    end else begin
      if (in_valid) dcnt <= dcnt == DW'(DECIM-1) ? '0 : dcnt + 1'b1;
      stg_v <= keep;
      stg_d <= sat_d;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
      sat_count <= clr_stats ? '0 : (keep && (hi || lo) && ~&sat_count) ? sat_count + 1'b1 : sat_count;
      ovf_count <= clr_stats ? '0 : (drop && ~&ovf_count) ? ovf_count + 1'b1 : ovf_count;
    end
  end
  // Storage is left unreset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= stg_d;
  end
endmodule

// File: tb/tb_fir_output_conditioner.sv
// tb_fir_output_conditioner: three parameterisations driven in lockstep against a queue-based reference model.
module tb_fir_output_conditioner;
  logic clk = 0, rst = 0, in_valid = 0, clr_stats = 0, m_ready = 0;
  logic [38:0] in_data = '0;
  logic mv [3];
  logic [15:0] md [3];
  logic [3:0] lv [3];
  logic [15:0] sc [3], oc [3];
  int sh [3] = '{0, 2, 0};
  int dc [3] = '{1, 1, 4};
  int q [3][$];
  bit sv [3];
  int sd [3], dcnt [3], esat [3], eovf [3];
  int ntests = 0, nfail = 0;

  always #5 clk = ~clk;

  fir_output_conditioner #(.SHIFT(0), .DECIM(1)) u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .clr_stats(clr_stats), .m_valid(mv[0]), .m_ready(m_ready), .m_data(md[0]), .fifo_level(lv[0]),
    .sat_count(sc[0]), .ovf_count(oc[0]));
  fir_output_conditioner #(.SHIFT(2), .DECIM(1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .clr_stats(clr_stats), .m_valid(mv[1]), .m_ready(m_ready), .m_data(md[1]), .fifo_level(lv[1]),
    .sat_count(sc[1]), .ovf_count(oc[1]));
  fir_output_conditioner #(.SHIFT(0), .DECIM(4)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .clr_stats(clr_stats), .m_valid(mv[2]), .m_ready(m_ready), .m_data(md[2]), .fifo_level(lv[2]),
    .sat_count(sc[2]), .ovf_count(oc[2]));

  function automatic int cond(input longint x, input int s, output bit sat);
    longint r;
    r = x;
    if (s > 0) r = (x + (64'sd1 <<< (s - 1))) >>> s;
    sat = r > 32767 || r < -32768;
    return r > 32767 ? 32767 : r < -32768 ? -32768 : int'(r);
  endfunction

  task automatic model();
    bit pop, s, keep, si, oi;
    int nd;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        q[k].delete();
        sv[k] = 0; sd[k] = 0; dcnt[k] = 0; esat[k] = 0; eovf[k] = 0;
      end else begin
        oi = 0;
        pop = q[k].size() > 0 && m_ready;
        if (pop) void'(q[k].pop_front());
        if (sv[k]) begin
          if (q[k].size() < 8) q[k].push_back(sd[k]);
          else oi = 1;
        end
        nd = cond(longint'($signed(in_data)), sh[k], s);
        keep = in_valid && dcnt[k] == 0;
        if (in_valid) dcnt[k] = (dcnt[k] + 1) % dc[k];
        si = keep && s;
        sv[k] = keep;
        sd[k] = nd;
        if (clr_stats) begin
          esat[k] = 0; eovf[k] = 0;
        end else begin
          if (si && esat[k] < 65535) esat[k]++;
          if (oi && eovf[k] < 65535) eovf[k]++;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("m_valid%0d", k), longint'(mv[k]), longint'(q[k].size() > 0));
      chk($sformatf("m_data%0d", k), longint'($signed(md[k])), q[k].size() > 0 ? q[k][0] : 0);
      chk($sformatf("level%0d", k), longint'(lv[k]), q[k].size());
      chk($sformatf("sat%0d", k), longint'(sc[k]), esat[k]);
      chk($sformatf("ovf%0d", k), longint'(oc[k]), eovf[k]);
    end
  endtask

  task automatic step(input bit v, input longint d, input bit rdy, input bit clr, input bit r);
    in_valid = v; in_data = d[38:0]; m_ready = rdy; clr_stats = clr; rst = r;
    @(posedge clk);
    model();
    #1;
    check_all();
  endtask

  initial begin
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("reset_level", longint'(lv[0]), 0);
    chk("reset_mdata", longint'(md[0]), 0);
    // saturation on u0, rounding on u1
    step(1, 40000, 1, 0, 0);
    step(1, -40000, 1, 0, 0);
    step(1, 1234, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    chk("sat_plan", longint'(sc[0]), 2);
    step(1, 6, 1, 0, 0);
    step(1, -6, 1, 0, 0);
    step(1, 5, 1, 0, 0);
    step(1, -5, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    // decimation on u2 with gapped input
    step(0, 0, 1, 0, 1);
    for (int i = 1; i <= 8; i++) begin
      step(1, i, 1, 0, 0);
      step(0, 0, 1, 0, 0);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    // overflow: ten samples into an 8-deep stalled FIFO
    step(0, 0, 0, 0, 1);
    for (int i = 1; i <= 10; i++) step(1, i, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("ovf_level", longint'(lv[0]), 8);
    chk("ovf_count", longint'(oc[0]), 2);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0);
    // push and pop on a full FIFO
    step(0, 0, 0, 0, 1);
    for (int i = 1; i <= 8; i++) step(1, i, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 99, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("pp_level", longint'(lv[0]), 8);
    chk("pp_ovf", longint'(oc[0]), 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0);
    // reset mid-operation and stats clear
    step(0, 0, 0, 0, 1);
    step(1, 40000, 0, 0, 0);
    step(1, -40000, 0, 0, 0);
    step(1, 50000, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rs_level", longint'(lv[0]), 5);
    chk("rs_sat", longint'(sc[0]), 3);
    step(0, 0, 1, 0, 1);
    chk("rs_after", longint'(mv[0]), 0);
    step(1, 40000, 0, 1, 0);
    chk("clr_sat", longint'(sc[0]), 0);
    step(0, 0, 1, 0, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom % 4 != 0, longint'($urandom_range(140000)) - 70000, $urandom % 3 != 0,
           $urandom % 50 == 0, $urandom % 200 == 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
